// File: rtl/mem_port_arbiter_r0.sv
// mem_port_arbiter_r0: shares one single-port memory between fetch and data
// accesses. One transaction at a time: grant, strobe the port, wait a fixed
// latency, return read data with a one-cycle valid pulse. Data accesses win
// ties unless fetch has been passed over STARVE_LIMIT times in a row.
module mem_port_arbiter_r0 #(
   parameter int unsigned BIT_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH   = 8,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 3
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_if_req,
   input  logic [ADDR_WIDTH-1:0] i_if_addr,
   output logic [BIT_WIDTH-1:0]  o_if_rdata,
   output logic                  o_if_valid,
   input  logic                  i_dm_req,
   input  logic                  i_dm_we,
   input  logic [ADDR_WIDTH-1:0] i_dm_addr,
   input  logic [BIT_WIDTH-1:0]  i_dm_wdata,
   output logic [BIT_WIDTH-1:0]  o_dm_rdata,
   output logic                  o_dm_valid,
   output logic                  o_mem_en,
   output logic                  o_mem_we,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [BIT_WIDTH-1:0]  o_mem_wdata,
   input  logic [BIT_WIDTH-1:0]  i_mem_rdata,
   output logic                  o_stall_if,
   output logic                  o_stall_mem,
   output logic                  o_busy
);

   localparam int unsigned CNT_W = 3;
   localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(MEM_LATENCY);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_ACCESS = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_state_nxt;
   logic [CNT_W-1:0]      r_lat_cnt;
   logic [CNT_W-1:0]      r_starve_cnt;
   logic                  r_owner_dm;
   logic                  r_is_store;
   logic                  r_mem_en;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [BIT_WIDTH-1:0]  r_mem_wdata;
   logic [BIT_WIDTH-1:0]  r_if_rdata;
   logic [BIT_WIDTH-1:0]  r_dm_rdata;
   logic                  r_if_valid;
   logic                  r_dm_valid;

   logic                  w_any_req;
   logic                  w_grant_if;
   logic                  w_grant;
   logic                  w_lat_last;

   // Arbitration: fetch wins only when alone or when it has hit the starvation limit
   always_comb begin
      w_any_req  = i_if_req | i_dm_req;
      w_grant_if = i_if_req & (~i_dm_req | (r_starve_cnt == STARVE_MAX));
      w_grant    = (r_state == S_IDLE) & w_any_req;
      w_lat_last = (r_lat_cnt == CNT_W'(1));
   end

   // Next-state logic for the IDLE -> ACCESS -> DONE sequence
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_any_req)  w_state_nxt = S_ACCESS;
         S_ACCESS: if (w_lat_last) w_state_nxt = S_DONE;
         S_DONE:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Grant capture: latch the winner onto the memory port and start the latency count
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_owner_dm   <= 1'b0;
         r_is_store   <= 1'b0;
         r_lat_cnt    <= '0;
         r_starve_cnt <= '0;
      end else begin
         r_mem_en <= 1'b0;
         r_mem_we <= 1'b0;
         if (w_grant) begin
            r_mem_en   <= 1'b1;
            r_owner_dm <= ~w_grant_if;
            r_lat_cnt  <= LAT_INIT;
            if (w_grant_if) begin
               r_mem_addr   <= i_if_addr;
               r_mem_wdata  <= '0;
               r_is_store   <= 1'b0;
               r_starve_cnt <= '0;
            end else begin
               r_mem_addr  <= i_dm_addr;
               r_mem_wdata <= i_dm_wdata;
               r_mem_we    <= i_dm_we;
               r_is_store  <= i_dm_we;
               if (!i_if_req)
                  r_starve_cnt <= '0;
               else if (r_starve_cnt != STARVE_MAX)
                  r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
         end else if (r_state == S_ACCESS) begin
            r_lat_cnt <= r_lat_cnt - CNT_W'(1);
         end
      end
   end

   // Completion: capture read data on the last ACCESS edge and pulse the owner's valid
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
         r_if_valid <= 1'b0;
         r_dm_valid <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_dm_valid <= 1'b0;
         if ((r_state == S_ACCESS) && w_lat_last) begin
            if (r_owner_dm) begin
               r_dm_valid <= 1'b1;
               if (!r_is_store) r_dm_rdata <= i_mem_rdata;
            end else begin
               r_if_valid <= 1'b1;
               r_if_rdata <= i_mem_rdata;
            end
         end
      end
   end

   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_if_rdata  = r_if_rdata;
   assign o_dm_rdata  = r_dm_rdata;
   assign o_if_valid  = r_if_valid;
   assign o_dm_valid  = r_dm_valid;
   assign o_busy      = (r_state != S_IDLE);
   assign o_stall_if  = i_if_req & ~r_if_valid;
   assign o_stall_mem = i_dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter_r0.sv
// Bench for mem_port_arbiter_r0: instance 0 uses MEM_LATENCY=1, instance 1 uses
// MEM_LATENCY=4. A timeline model predicts every output each cycle.
module tb_mem_port_arbiter_r0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst       [2];
   logic        if_req    [2];
   logic [7:0]  if_addr   [2];
   logic [31:0] if_rdata  [2];
   logic        if_valid  [2];
   logic        dm_req    [2];
   logic        dm_we     [2];
   logic [7:0]  dm_addr   [2];
   logic [31:0] dm_wdata  [2];
   logic [31:0] dm_rdata  [2];
   logic        dm_valid  [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [7:0]  mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        stall_if  [2];
   logic        stall_mem [2];
   logic        busy      [2];

   mem_port_arbiter_r0 #(.BIT_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(1), .STARVE_LIMIT(3)) dut0 (
      .i_clk(clk), .i_rst(rst[0]),
      .i_if_req(if_req[0]), .i_if_addr(if_addr[0]), .o_if_rdata(if_rdata[0]), .o_if_valid(if_valid[0]),
      .i_dm_req(dm_req[0]), .i_dm_we(dm_we[0]), .i_dm_addr(dm_addr[0]), .i_dm_wdata(dm_wdata[0]),
      .o_dm_rdata(dm_rdata[0]), .o_dm_valid(dm_valid[0]),
      .o_mem_en(mem_en[0]), .o_mem_we(mem_we[0]), .o_mem_addr(mem_addr[0]), .o_mem_wdata(mem_wdata[0]),
      .i_mem_rdata(mem_rdata[0]), .o_stall_if(stall_if[0]), .o_stall_mem(stall_mem[0]), .o_busy(busy[0]));

   mem_port_arbiter_r0 #(.BIT_WIDTH(32), .ADDR_WIDTH(8), .MEM_LATENCY(4), .STARVE_LIMIT(3)) dut1 (
      .i_clk(clk), .i_rst(rst[1]),
      .i_if_req(if_req[1]), .i_if_addr(if_addr[1]), .o_if_rdata(if_rdata[1]), .o_if_valid(if_valid[1]),
      .i_dm_req(dm_req[1]), .i_dm_we(dm_we[1]), .i_dm_addr(dm_addr[1]), .i_dm_wdata(dm_wdata[1]),
      .o_dm_rdata(dm_rdata[1]), .o_dm_valid(dm_valid[1]),
      .o_mem_en(mem_en[1]), .o_mem_we(mem_we[1]), .o_mem_addr(mem_addr[1]), .o_mem_wdata(mem_wdata[1]),
      .i_mem_rdata(mem_rdata[1]), .o_stall_if(stall_if[1]), .o_stall_mem(stall_mem[1]), .o_busy(busy[1]));

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ---------------- timeline model ----------------
   // A transaction granted at the end of cycle T strobes the port in T+1,
   // samples read data at the end of T+L, pulses valid in T+L+1 and leaves
   // the arbiter free to grant again at the end of T+L+2.
   bit          m_act      [2];
   int          m_t        [2];
   bit          m_dm       [2];
   bit          m_we       [2];
   logic [7:0]  m_addr     [2];
   logic [31:0] m_wdata    [2];
   bit          m_wd_known [2];
   int          m_starve   [2];
   logic [31:0] m_ifr      [2];
   logic [31:0] m_dmr      [2];

   localparam int STARVE = 3;

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   task automatic model_clear(input int k);
      m_act[k] = 1'b0; m_t[k] = 0; m_dm[k] = 1'b0; m_we[k] = 1'b0;
      m_addr[k] = '0; m_wdata[k] = '0; m_wd_known[k] = 1'b1;
      m_starve[k] = 0; m_ifr[k] = '0; m_dmr[k] = '0;
   endtask

   task automatic model_step(input int k, input int p);
      int  lat;
      bit  idle;
      bit  if_wins;
      lat = lat_of(k);
      if (!rst[k]) begin
         model_clear(k);
      end else begin
         if (m_act[k] && p == m_t[k] + lat && !m_we[k]) begin
            if (m_dm[k]) m_dmr[k] = mem_rdata[k];
            else         m_ifr[k] = mem_rdata[k];
         end
         idle = !m_act[k] || (p > m_t[k] + lat + 1);
         if (idle && (if_req[k] || dm_req[k])) begin
            if_wins = if_req[k] && (!dm_req[k] || m_starve[k] == STARVE);
            m_act[k] = 1'b1;
            m_t[k]   = p;
            if (if_wins) begin
               m_dm[k] = 1'b0; m_we[k] = 1'b0; m_addr[k] = if_addr[k];
               m_wd_known[k] = 1'b0; m_starve[k] = 0;
            end else begin
               m_dm[k] = 1'b1; m_we[k] = dm_we[k]; m_addr[k] = dm_addr[k];
               m_wdata[k] = dm_wdata[k]; m_wd_known[k] = 1'b1;
               m_starve[k] = if_req[k] ? ((m_starve[k] < STARVE) ? m_starve[k] + 1 : STARVE) : 0;
            end
         end
      end
   endtask

   initial begin
      model_clear(0);
      model_clear(1);
      forever begin
         @(posedge clk);
         model_step(0, cyc);
         model_step(1, cyc);
         cyc = cyc + 1;
      end
   end

   initial forever begin @(negedge rst[0]); model_clear(0); end
   initial forever begin @(negedge rst[1]); model_clear(1); end

   // Per-cycle compare of every output against the model
   task automatic compare_dut(input int k);
      int  lat;
      int  rel;
      bit  e_en, e_ifv, e_dmv, e_busy;
      string s;
      lat    = lat_of(k);
      rel    = cyc - m_t[k];
      e_busy = m_act[k] && rel >= 1 && rel <= lat + 1;
      e_en   = m_act[k] && rel == 1;
      e_ifv  = m_act[k] && rel == lat + 1 && !m_dm[k];
      e_dmv  = m_act[k] && rel == lat + 1 &&  m_dm[k];
      s = $sformatf("d%0d", k);
      chk({s, ".mem_en"},    32'(mem_en[k]),   32'(e_en));
      chk({s, ".mem_we"},    32'(mem_we[k]),   32'(e_en && m_we[k]));
      chk({s, ".mem_addr"},  32'(mem_addr[k]), 32'(m_addr[k]));
      if (m_wd_known[k]) chk({s, ".mem_wdata"}, mem_wdata[k], m_wdata[k]);
      chk({s, ".if_valid"},  32'(if_valid[k]), 32'(e_ifv));
      chk({s, ".dm_valid"},  32'(dm_valid[k]), 32'(e_dmv));
      chk({s, ".if_rdata"},  if_rdata[k],      m_ifr[k]);
      chk({s, ".dm_rdata"},  dm_rdata[k],      m_dmr[k]);
      chk({s, ".busy"},      32'(busy[k]),     32'(e_busy));
      chk({s, ".stall_if"},  32'(stall_if[k]), 32'(if_req[k] && !e_ifv));
      chk({s, ".stall_mem"}, 32'(stall_mem[k]),32'(dm_req[k] && !e_dmv));
   endtask

   initial forever begin
      @(negedge clk);
      compare_dut(0);
      compare_dut(1);
   end

   // ---------------- stimulus helpers ----------------
   logic [7:0]  g_addr [$];
   int          g_cyc  [$];
   int          en_n, we_n, en_cyc, dmv_cyc;
   logic [31:0] st_wdata;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Hold requests until they complete; dm re-requests n_dm times with incrementing address
   task automatic serve(input int k, input int n_dm, input int maxc);
      int left;
      int c;
      bit fv, dv;
      left = n_dm; c = 0;
      g_addr.delete(); g_cyc.delete();
      en_n = 0; we_n = 0; en_cyc = -1; dmv_cyc = -1; st_wdata = '0;
      while ((if_req[k] || dm_req[k]) && c < maxc) begin
         @(negedge clk);
         c++;
         if (mem_en[k]) begin
            g_addr.push_back(mem_addr[k]);
            g_cyc.push_back(cyc);
            en_n++;
            if (en_cyc < 0) en_cyc = cyc;
            if (mem_we[k]) begin we_n++; st_wdata = mem_wdata[k]; end
         end
         fv = if_valid[k];
         dv = dm_valid[k];
         if (dv && dmv_cyc < 0) dmv_cyc = cyc;
         tick();
         if (fv) if_req[k] = 1'b0;
         if (dv) begin
            left--;
            if (left > 0) dm_addr[k] = dm_addr[k] + 8'd1;
            else          dm_req[k]  = 1'b0;
         end
      end
      if (c >= maxc) begin
         chk("serve_timeout", 32'(c), 32'(maxc - 1));
         if_req[k] = 1'b0;
         dm_req[k] = 1'b0;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // ---------------- directed tests ----------------
   initial begin : stim
      int t_req, v_cyc, en1;
      logic [7:0] exp_order [5];
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; dm_req[k] = 1'b0;
         dm_we[k] = 1'b0; dm_addr[k] = '0; dm_wdata[k] = '0; mem_rdata[k] = '0;
      end
      if_req[0] = 1'b1; if_addr[0] = 8'h04; mem_rdata[0] = 32'h2402000A;
      repeat (3) tick();

      // Reset with fetch request held
      @(negedge clk);
      chk("rst.mem_en",   32'(mem_en[0]),   32'd0);
      chk("rst.mem_addr", 32'(mem_addr[0]), 32'd0);
      chk("rst.if_rdata", if_rdata[0],      32'd0);
      chk("rst.busy",     32'(busy[0]),     32'd0);
      chk("rst.stall_if", 32'(stall_if[0]), 32'd1);

      // Release reset: fetch of 0x04 completes two cycles later
      tick();
      rst[0] = 1'b1; rst[1] = 1'b1;
      @(negedge clk);
      chk("t1.stall_if_c0", 32'(stall_if[0]), 32'd1);
      @(negedge clk);
      chk("t1.mem_en_c1",   32'(mem_en[0]),   32'd1);
      chk("t1.mem_addr_c1", 32'(mem_addr[0]), 32'h04);
      @(negedge clk);
      chk("t1.if_valid_c2", 32'(if_valid[0]), 32'd1);
      chk("t1.if_rdata_c2", if_rdata[0],      32'h2402000A);
      chk("t1.stall_if_c2", 32'(stall_if[0]), 32'd0);
      tick();
      if_req[0] = 1'b0;

      // Simultaneous fetch and load: load first, fetch three cycles later
      if_req[0] = 1'b1; if_addr[0] = 8'h10;
      dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 8'h80;
      mem_rdata[0] = 32'h11111111;
      serve(0, 1, 30);
      chk("t2.n_grants", 32'(g_addr.size()), 32'd2);
      if (g_addr.size() == 2) begin
         chk("t2.first_addr",  32'(g_addr[0]), 32'h80);
         chk("t2.second_addr", 32'(g_addr[1]), 32'h10);
         chk("t2.gap",         32'(g_cyc[1] - g_cyc[0]), 32'd3);
      end
      chk("t2.dm_rdata", dm_rdata[0], 32'h11111111);

      // Store: one strobe with write enable, valid one cycle later, rdata held
      dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 8'h20; dm_wdata[0] = 32'hDEADBEEF;
      mem_rdata[0] = 32'h55AA55AA;
      serve(0, 1, 20);
      chk("t3.en_cycles", 32'(en_n), 32'd1);
      chk("t3.we_cycles", 32'(we_n), 32'd1);
      chk("t3.wdata",     st_wdata,  32'hDEADBEEF);
      chk("t3.valid_lat", 32'(dmv_cyc - en_cyc), 32'd1);
      chk("t3.dm_rdata",  dm_rdata[0], 32'h11111111);
      dm_we[0] = 1'b0;

      // Starvation: continuous loads against a held fetch
      if_req[0] = 1'b1; if_addr[0] = 8'h30;
      dm_req[0] = 1'b1; dm_addr[0] = 8'h40; mem_rdata[0] = 32'h22222222;
      exp_order[0] = 8'h40; exp_order[1] = 8'h41; exp_order[2] = 8'h42;
      exp_order[3] = 8'h30; exp_order[4] = 8'h43;
      serve(0, 4, 60);
      chk("t4.n_grants", 32'(g_addr.size()), 32'd5);
      for (int i = 0; i < 5; i++)
         if (i < g_addr.size()) chk($sformatf("t4.grant%0d", i), 32'(g_addr[i]), 32'(exp_order[i]));

      // MEM_LATENCY=4: only the final ACCESS edge samples read data
      tick();
      dm_req[1] = 1'b1; dm_addr[1] = 8'h55; mem_rdata[1] = 32'hBAD00000;
      t_req = cyc; v_cyc = -1; en1 = 0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (mem_en[1]) en1++;
         if (dm_valid[1] && v_cyc < 0) v_cyc = cyc;
         tick();
         mem_rdata[1] = (i == 4) ? 32'hC0FFEE00 : (32'hBAD00000 | 32'(i));
         if (v_cyc >= 0) dm_req[1] = 1'b0;
      end
      chk("t5.en_cycles", 32'(en1), 32'd1);
      chk("t5.valid_lat", 32'(v_cyc - t_req), 32'd5);
      chk("t5.dm_rdata",  dm_rdata[1], 32'hC0FFEE00);

      // Reset in the middle of a load: no valid, rdata cleared, regrant after release
      tick();
      dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_addr[0] = 8'h66; mem_rdata[0] = 32'h77777777;
      tick();
      rst[0] = 1'b0;
      @(negedge clk);
      chk("t6.dm_valid", 32'(dm_valid[0]), 32'd0);
      chk("t6.dm_rdata", dm_rdata[0],      32'd0);
      chk("t6.busy",     32'(busy[0]),     32'd0);
      chk("t6.mem_en",   32'(mem_en[0]),   32'd0);
      tick();
      @(negedge clk);
      chk("t6.dm_valid_hold", 32'(dm_valid[0]), 32'd0);
      tick();
      rst[0] = 1'b1;
      serve(0, 1, 20);
      chk("t6.regrant_addr", (g_addr.size() > 0) ? 32'(g_addr[0]) : 32'hFFFFFFFF, 32'h66);
      chk("t6.dm_rdata_after", dm_rdata[0], 32'h77777777);

      repeat (3) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter_r0.md
# mem_port_arbiter_r0

Arbiter and sequencer that shares one single-port unified memory between the fetch stage (instruction reads) and the memory stage (data loads/stores) of the 5-stage pipeline. It grants one access at a time, drives the memory port, waits a fixed memory latency, and returns read data with a one-cycle valid pulse. It generates per-stage stall signals for the pipeline registers. Data accesses have priority, bounded by an anti-starvation limit for fetch.

## Interface
- BIT_WIDTH, 32, data width
- ADDR_WIDTH, 8, memory word-address width
- MEM_LATENCY, 1, cycles from the memory sampling mem_en to mem_rdata valid; legal range 1..7
- STARVE_LIMIT, 3, max consecutive data grants while if_req pends; legal range 1..7

- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch read request, held until if_valid
- if_addr  in  ADDR_WIDTH  fetch address, stable while if_req
- if_rdata  out  BIT_WIDTH  fetch read data, registered
- if_valid  out  1  one-cycle fetch completion pulse
- dm_req  in  1  data request, held until dm_valid
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_WIDTH  data address
- dm_wdata  in  BIT_WIDTH  store data
- dm_rdata  out  BIT_WIDTH  load data, registered
- dm_valid  out  1  one-cycle data completion pulse
- mem_en  out  1  memory access strobe, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_WIDTH  memory address, registered
- mem_wdata  out  BIT_WIDTH  memory write data, registered
- mem_rdata  in  BIT_WIDTH  memory read data
- stall_if  out  1  if_req & ~if_valid, combinational
- stall_mem  out  1  dm_req & ~dm_valid, combinational
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: at the edge, if any request is pending, grant one. Load mem_addr/mem_wdata/mem_we from the winner, set mem_en=1, set owner, load lat_cnt=MEM_LATENCY, go to ACCESS. With no request, stay in IDLE.
- Grant rule: dm wins when both are pending, unless starve_cnt == STARVE_LIMIT; then if wins.
- starve_cnt (3 bit):
  - increments on a dm grant while if_req=1.
  - clears on any if grant, and on a dm grant while if_req=0.
  - saturates at STARVE_LIMIT.
- ACCESS:
  - mem_en=1 and mem_we only in the first ACCESS cycle; both are 0 afterwards. mem_addr/mem_wdata hold.
  - lat_cnt decrements each cycle.
  - At the edge where lat_cnt==1, capture mem_rdata into owner's rdata (loads/fetch only) and go to DONE.
- DONE: the owner's valid=1 for exactly one cycle; no arbitration; next state is IDLE.
- Stores: mem_we=1 with mem_en. dm_valid still pulses in DONE. dm_rdata retains its previous value.
- if_rdata/dm_rdata hold their value until the next completing read for that requester.
- A request dropped mid-transaction is a protocol violation: the access completes and valid still pulses.
- Only one transaction is ever outstanding. mem_we is never 1 for a fetch grant.

## Timing
- Reset (rst=0, asynchronous):
  - state=IDLE; starve_cnt=0, lat_cnt=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - if_rdata=0, dm_rdata=0, if_valid=0, dm_valid=0, busy=0.
  - stall_* still follow req.
- Reset mid-ACCESS aborts the transaction with no valid pulse. A store already strobed may have been written.
- Request seen in IDLE in cycle T:
  - mem_en high in cycle T+1.
  - valid high in cycle T+1+MEM_LATENCY.
  - earliest next grant decision at the end of cycle T+2+MEM_LATENCY (IDLE).
- Throughput: one access per MEM_LATENCY+2 cycles.
- stall_if/stall_mem are combinational and fall in the same cycle the valid pulses.

## Test plan
- Reset with if_req=1 held: all registered outputs 0, stall_if=1. Release rst at cycle 0 with if_addr=0x04, mem_rdata=0x2402000A: mem_en=1, mem_addr=0x04 in cycle 1; if_valid=1, if_rdata=0x2402000A in cycle 2; stall_if=0 in cycle 2.
- Simultaneous if_req (addr 0x10) and dm_req load (addr 0x80) in IDLE: the dm access is issued first (mem_addr=0x80). Fetch is issued 3 cycles later (MEM_LATENCY=1); stall_if stays high until its valid.
- Store with dm_addr=0x20, dm_wdata=0xDEADBEEF: a single cycle with mem_en=1, mem_we=1, mem_wdata=0xDEADBEEF. dm_valid pulses 1 cycle later; dm_rdata is unchanged.
- Starvation, STARVE_LIMIT=3, dm_req re-asserted continuously, if_req held: grant order dm, dm, dm, if, dm. starve_cnt returns to 0 after the if grant.
- MEM_LATENCY=4: exactly one mem_en cycle and valid 5 cycles after the request cycle. mem_rdata is sampled only at the final ACCESS edge; earlier garbage values are ignored.
- Assert rst mid-ACCESS of a load: no dm_valid, dm_rdata=0, state returns to IDLE. A pending request is re-granted normally after release.
